jpeg_pipe_sequencer: RTL and testbench

Parametrised control sequencer for the row-serial JPEG pipeline (DCT → transpose → DCT → transpose → quantiser → zig-zag). It generates the input-memory read address, the output-memory write address, the per-stage ping-pong select for the double-buffered stages, and the row index used by the second DCT and the quantiser. It replaces free-running saturating counters with a start/done frame handshake, a programmable frame length, a stall input, and an arbitrary number of ping-pong stages.

---
 rtl/jpeg_pipe_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_jpeg_pipe_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_pipe_sequencer.sv
// jpeg_pipe_sequencer
// Frame-level control sequencer for the row-serial JPEG pipeline
// (DCT -> transpose -> DCT -> transpose -> quantiser -> zig-zag).
//
// Build option: define JPEG_SEQ_STALL_EN to make the stall input freeze the
// sequencer. When the macro is undefined, stall is ignored and every RUN and
// DRAIN cycle is active.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset, clears all state
//   start      in   frame request, sampled in IDLE only
//   frame_rows in   rows per frame, latched when start is accepted
//   stall      in   freezes the sequencer for the current cycle
//   in_rd      out  input memory read strobe
//   in_addr    out  input memory row address
//   out_wr     out  output memory write strobe
//   out_addr   out  output memory row address
//   pp_sel     out  ping-pong select, one bit per double-buffered stage
//   row_idx    out  row-within-block index for DCT2 / quantiser
//   busy       out  high in RUN and DRAIN
//   done       out  one-cycle end-of-frame pulse
module jpeg_pipe_sequencer #(
  parameter int                       ADDR_W    = 15,
  parameter int                       BLK_LOG2  = 3,
  parameter int                       NSTAGE    = 3,
  parameter int                       OFS_W     = 6,
  parameter logic [NSTAGE*OFS_W-1:0]  STAGE_OFS = {6'd18, 6'd9, 6'd0},
  parameter int                       OUT_LAT   = 28,
  parameter int                       ROW_OFS   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   frame_rows,
  input  logic                stall,
  output logic                in_rd,
  output logic [ADDR_W-1:0]   in_addr,
  output logic                out_wr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [NSTAGE-1:0]   pp_sel,
  output logic [BLK_LOG2-1:0] row_idx,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Tick counter is one bit wider than the addresses so OUT_LAT + rows fits.
  localparam int                 TW         = ADDR_W + 1;
  localparam logic [TW-1:0]      OUT_LAT_T  = TW'(OUT_LAT);
  localparam logic [TW-1:0]      BLK_MASK_T = TW'((1 << BLK_LOG2) - 1);
  localparam logic [BLK_LOG2-1:0] ROW_OFS_B = BLK_LOG2'(ROW_OFS);

  // First toggle tick of stage k, widened to the tick width.
  function automatic logic [TW-1:0] stage_ofs(input int k);
    return TW'(STAGE_OFS[k*OFS_W +: OFS_W]);
  endfunction

  // Next ping-pong value for one stage in an active cycle at tick t.
  function automatic logic pp_next(input logic cur, input logic [TW-1:0] t,
                                   input logic [TW-1:0] ofs);
    logic nxt;
    if (t == ofs) begin
      nxt = 1'b1;
    end else if ((t > ofs) && (((t - ofs) & BLK_MASK_T) == '0)) begin
      nxt = ~cur;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

  state_e              state_q, state_d;
  logic [TW-1:0]       t_q, t_d;
  logic [ADDR_W-1:0]   in_addr_q, in_addr_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [ADDR_W-1:0]   rows_q, rows_d;
  logic [NSTAGE-1:0]   pp_q, pp_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                stall_s;
  logic                active_s;
  logic                rd_now_s;
  logic                wr_now_s;

`ifdef JPEG_SEQ_STALL_EN
  assign stall_s = stall;
`else
  logic stall_unused_s;
  assign stall_unused_s = stall;
  assign stall_s        = 1'b0;
`endif

  // rd_q / wr_q hold the access scheduled for this cycle; a stall cancels it.
  assign active_s = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !stall_s;
  assign rd_now_s = rd_q && !stall_s;
  assign wr_now_s = wr_q && !stall_s;

  // Next-state, counters and ping-pong selects.
  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    in_addr_d  = in_addr_q;
    out_addr_d = out_addr_q;
    rows_d     = rows_q;
    pp_d       = pp_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d = frame_rows;
          if (frame_rows != '0) begin
            state_d    = S_RUN;
            t_d        = '0;
            in_addr_d  = '0;
            out_addr_d = '0;
            pp_d       = '0;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN, S_DRAIN: begin
        if (active_s) begin
          t_d = t_q + TW'(1);
          for (int k = 0; k < NSTAGE; k++) begin
            pp_d[k] = pp_next(pp_q[k], t_q, stage_ofs(k));
          end
          if (rd_now_s) begin
            in_addr_d = in_addr_q + ADDR_W'(1);
          end else begin
            in_addr_d = in_addr_q;
          end
          if (wr_now_s) begin
            out_addr_d = out_addr_q + ADDR_W'(1);
          end else begin
            out_addr_d = out_addr_q;
          end
          // Last write wins over last read when both land in the same cycle.
          if (wr_now_s && (out_addr_q == rows_q - ADDR_W'(1))) begin
            state_d = S_DONE;
          end else if (rd_now_s && (in_addr_q == rows_q - ADDR_W'(1))) begin
            state_d = S_DRAIN;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered strobes and status derived from the next state.
  always_comb begin
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    rd_d   = (state_d == S_RUN);
    wr_d   = busy_d && (t_d >= OUT_LAT_T) && (out_addr_d < rows_d);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      in_addr_q  <= '0;
      out_addr_q <= '0;
      rows_q     <= '0;
      pp_q       <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      in_addr_q  <= in_addr_d;
      out_addr_q <= out_addr_d;
      rows_q     <= rows_d;
      pp_q       <= pp_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_rd    = rd_now_s;
  assign out_wr   = wr_now_s;
  assign in_addr  = in_addr_q;
  assign out_addr = out_addr_q;
  assign pp_sel   = pp_q;
  assign busy     = busy_q;
  assign done     = done_q;
  // Row index lags the tick by ROW_OFS rows, wrapping within the block.
  assign row_idx  = ((state_q == S_RUN) || (state_q == S_DRAIN))
                    ? (t_q[BLK_LOG2-1:0] - ROW_OFS_B) : '0;

endmodule

// File: tb/tb_jpeg_pipe_sequencer.sv
// Self-checking bench for jpeg_pipe_sequencer. The reference model tracks
// only the number of active cycles in the current frame and derives every
// expected output from it arithmetically.
module tb_jpeg_pipe_sequencer;

  localparam int ADDR_W = 15;
  localparam int OL     = 28;
  localparam int BLK    = 8;
  localparam int OFS [3] = '{0, 9, 18};

`ifdef JPEG_SEQ_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] frame_rows;
  logic              stall;
  logic              in_rd;
  logic [ADDR_W-1:0] in_addr;
  logic              out_wr;
  logic [ADDR_W-1:0] out_addr;
  logic [2:0]        pp_sel;
  logic [2:0]        row_idx;
  logic              busy;
  logic              done;

  jpeg_pipe_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .frame_rows (frame_rows),
    .stall      (stall),
    .in_rd      (in_rd),
    .in_addr    (in_addr),
    .out_wr     (out_wr),
    .out_addr   (out_addr),
    .pp_sel     (pp_sel),
    .row_idx    (row_idx),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: m_a active cycles done in frame of m_R rows; phase 0 idle, 1 busy, 2 done.
  int m_a   = 0;
  int m_R   = 0;
  int phase = 0;

  function automatic int exp_pp(input int a);
    int v;
    v = 0;
    for (int k = 0; k < 3; k++) begin
      if (a > OFS[k]) v = v | ((((a - 1 - OFS[k]) / BLK + 1) & 1) << k);
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit bz;
    bit st;
    bz = (phase == 1);
    st = STALL_EN && stall;
    chk("in_rd",    in_rd,    bz && (m_a < m_R) && !st);
    chk("in_addr",  in_addr,  (m_a < m_R) ? m_a : m_R);
    chk("out_wr",   out_wr,   bz && (m_a >= OL) && !st);
    chk("out_addr", out_addr, (m_a < OL) ? 0 : (((m_a - OL) < m_R) ? (m_a - OL) : m_R));
    chk("pp_sel",   pp_sel,   exp_pp(m_a));
    chk("row_idx",  row_idx,  bz ? ((m_a - 3) & (BLK - 1)) : 0);
    chk("busy",     busy,     bz);
    chk("done",     done,     phase == 2);
  endtask

  // Runs one frame from an IDLE cycle (entered at posedge+1) and returns at
  // posedge+1 of the following IDLE cycle. mode: 0 quiet, 1 random stall and
  // stray starts, 2 three-cycle stall at t=8. abort_at >= 0 resets mid-frame.
  task automatic run_frame(input int rows, input int mode, input int abort_at);
    int  cyc;
    int  nst;
    int  stall_left;
    bit  stalled_once;
    bit  finished;
    cyc          = 1;
    nst          = 0;
    stall_left   = 0;
    stalled_once = 1'b0;
    finished     = 1'b0;
    start        = 1'b1;
    frame_rows   = ADDR_W'(rows);
    stall        = 1'b0;
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    start      = 1'b0;
    frame_rows = ADDR_W'($urandom);
    if (rows == 0) begin
      phase = 2;
    end else begin
      m_a   = 0;
      m_R   = rows;
      phase = 1;
    end
    for (int c = 0; c < OL + rows + 300; c++) begin
      if ((abort_at >= 0) && (phase == 1) && (m_a == abort_at)) begin
        stall = 1'b0;
        start = 1'b0;
        reset = 1'b0;
        #1;
        m_a   = 0;
        m_R   = 0;
        phase = 0;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
        finished = 1'b1;
        break;
      end
      if (phase == 1 && mode == 1) begin
        stall = ($urandom_range(0, 3) == 0);
        start = ($urandom_range(0, 7) == 0);
      end else if (phase == 1 && mode == 2) begin
        if (m_a == 8 && !stalled_once) begin
          stall_left   = 3;
          stalled_once = 1'b1;
        end
        stall = (stall_left > 0);
        if (stall_left > 0) stall_left--;
      end else begin
        stall = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
      check_all();
      if (phase == 2) begin
        chk("done_cycle", cyc, (rows == 0) ? 1 : (OL + rows + 1 + nst));
        phase = 0;
        stall = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        finished = 1'b1;
        break;
      end
      if (phase == 1) begin
        if (STALL_EN && stall) begin
          nst++;
        end else begin
          m_a++;
          if (m_a == OL + m_R) phase = 2;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    assert (finished) else begin
      failures++;
      $error("FAIL frame_timeout rows=%0d observed=no_done expected=done", rows);
    end
    stall = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    stall      = 1'b0;
    frame_rows = '0;
    #12;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // Nominal 64-row frame, then a back-to-back frame with a stall at t=8.
    run_frame(64, 0, -1);
    run_frame(64, 2, -1);
    // Zero-length frame.
    run_frame(0, 0, -1);
    // Reset in the middle of a frame, then a clean frame.
    run_frame(40, 0, 20);
    run_frame(10, 0, -1);
    // Short frames where the last read and last write are far apart.
    run_frame(1, 0, -1);
    run_frame(1, 1, -1);
    // Randomized frames with random stalls and stray starts while busy.
    for (int i = 0; i < 6; i++) begin
      run_frame($urandom_range(1, 50), 1, -1);
    end
    run_frame(0, 1, -1);
    run_frame(9, 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
